// File: rtl/traffic_timer.sv
// traffic_timer: 4-bit tick countdown timer driven by traffic_light_controller.
// Define TRAFFIC_TIMER_PRESCALE_EN to divide clk by CLKS_PER_TICK; undefined, every enabled RUN cycle is a tick.
module traffic_timer #(
   parameter int unsigned CLKS_PER_TICK = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       timer_en,
   input  logic       timer_load,
   input  logic [3:0] timer_init,
   output logic [3:0] timer_out,
   output logic       done,
   output logic       expired,
   output logic       tick
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state;
   logic   boundary;

`ifdef TRAFFIC_TIMER_PRESCALE_EN
   localparam int unsigned PW = $clog2(CLKS_PER_TICK);
   localparam logic [PW-1:0] LAST = PW'(CLKS_PER_TICK - 1);

   logic [PW-1:0] prescaler;

   assign boundary = (prescaler == LAST);
`else
   // Without the prescaler every cycle is a boundary; CLKS_PER_TICK is always >= 2.
   assign boundary = (CLKS_PER_TICK != 0);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         timer_out <= 4'd0;
         tick      <= 1'b0;
         expired   <= 1'b0;
`ifdef TRAFFIC_TIMER_PRESCALE_EN
         prescaler <= '0;
`endif
      end else if (timer_load) begin
         // Load beats any coincident tick boundary: no decrement, tick or expired.
         state     <= (timer_init != 4'd0) ? RUN : DONE;
         timer_out <= timer_init;
         tick      <= 1'b0;
         expired   <= 1'b0;
`ifdef TRAFFIC_TIMER_PRESCALE_EN
         prescaler <= '0;
`endif
      end else begin
         tick    <= 1'b0;
         expired <= 1'b0;
         case (state)
            RUN: begin
               if (timer_en) begin
`ifdef TRAFFIC_TIMER_PRESCALE_EN
                  prescaler <= boundary ? '0 : prescaler + 1'b1;
`endif
                  if (boundary) begin
                     tick      <= 1'b1;
                     timer_out <= timer_out - 4'd1;
                     if (timer_out == 4'd1) begin
                        expired <= 1'b1;
                        state   <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               timer_out <= 4'd0;
`ifdef TRAFFIC_TIMER_PRESCALE_EN
               prescaler <= '0;
`endif
            end
            default: begin
               timer_out <= 4'd0;
            end
         endcase
      end
   end

   assign done = (timer_out == 4'd0);

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer with a countdown reference model based on elapsed enabled cycles.
// Follows TRAFFIC_TIMER_PRESCALE_EN: period 4 when defined, 1 when undefined.
module tb_traffic_timer;

`ifdef TRAFFIC_TIMER_PRESCALE_EN
   localparam int P = 4;
`else
   localparam int P = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       timer_en = 1'b0;
   logic       timer_load = 1'b0;
   logic [3:0] timer_init = 4'd0;
   logic [3:0] timer_out;
   logic       done;
   logic       expired;
   logic       tick;

   int vectors = 0;
   int miscompares = 0;

   traffic_timer #(.CLKS_PER_TICK(4)) dut (
      .clk(clk),
      .rst(rst),
      .timer_en(timer_en),
      .timer_load(timer_load),
      .timer_init(timer_init),
      .timer_out(timer_out),
      .done(done),
      .expired(expired),
      .tick(tick)
   );

   always #5 clk = ~clk;

   // Reference: remaining = loaded value minus whole periods of enabled cycles since the load.
   bit m_loaded = 1'b0;
   int m_init = 0;
   int m_elapsed = 0;
   bit m_tick = 1'b0;
   bit m_expired = 1'b0;
   int m_e;

   function automatic logic [3:0] m_out();
      if (!m_loaded) return 4'd0;
      return 4'(m_init - m_elapsed / P);
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_loaded <= 1'b0; m_init <= 0; m_elapsed <= 0; m_tick <= 1'b0; m_expired <= 1'b0;
      end else if (timer_load) begin
         m_loaded <= 1'b1; m_init <= int'(timer_init); m_elapsed <= 0; m_tick <= 1'b0; m_expired <= 1'b0;
      end else if (m_loaded && timer_en && (m_init - m_elapsed / P) > 0) begin
         m_e = m_elapsed + 1;
         m_elapsed <= m_e;
         m_tick    <= (m_e % P == 0);
         m_expired <= (m_e % P == 0) && (m_init - m_e / P == 0);
      end else begin
         m_tick <= 1'b0; m_expired <= 1'b0;
      end
   end

   task automatic test_reset();
      rst = 1'b0; timer_load = 1'b1; timer_init = 4'd7; timer_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (timer_out !== 4'd0 || done !== 1'b1 || tick !== 1'b0 || expired !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: out=%0d done=%b tick=%b exp=%b, want 0 1 0 0", timer_out, done, tick, expired);
      end
      rst = 1'b1; timer_load = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (timer_out !== 4'd0 || tick !== 1'b0 || expired !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_en_only c=%0d: out=%0d tick=%b exp=%b done=%b, want 0 0 0 1", c, timer_out, tick, expired, done);
         end
      end
   endtask

   task automatic test_countdown();
      int exp_cnt = 0;
      int want;
      timer_load = 1'b1; timer_init = 4'd3; timer_en = 1'b1;
      @(posedge clk); #1;
      timer_load = 1'b0;
      for (int c = 1; c <= 3 * P + 6; c++) begin
         @(posedge clk); #1;
         if (expired === 1'b1) exp_cnt++;
         want = (c / P >= 3) ? 0 : 3 - c / P;
         vectors++;
         if (timer_out !== 4'(want) || done !== (want == 0) || expired !== (c == 3 * P)) begin
            miscompares++;
            $display("[TB] FAIL countdown c=%0d: out=%0d done=%b exp=%b, want %0d %b %b", c, timer_out, done, expired, want, want == 0, c == 3 * P);
         end
      end
      vectors++;
      if (exp_cnt != 1) begin
         miscompares++;
         $display("[TB] FAIL expired_count: got %0d pulses, want 1", exp_cnt);
      end
   endtask

   task automatic test_pause();
      timer_load = 1'b1; timer_init = 4'd5; timer_en = 1'b1;
      @(posedge clk); #1;
      timer_load = 1'b0;
      for (int c = 0; c < 6 + 10 + 3 * P + 4; c++) begin
         timer_en = (c >= 6 && c < 16) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
         vectors++;
         if (timer_out !== m_out() || tick !== m_tick || expired !== m_expired || done !== (m_out() == 4'd0)) begin
            miscompares++;
            $display("[TB] FAIL pause c=%0d: out=%0d tick=%b exp=%b, want %0d %b %b", c, timer_out, tick, expired, m_out(), m_tick, m_expired);
         end
`ifdef TRAFFIC_TIMER_PRESCALE_EN
         if (c >= 5 && c <= 16) begin
            vectors++;
            if (timer_out !== 4'd4) begin
               miscompares++;
               $display("[TB] FAIL pause_hold c=%0d: out=%0d, want 4", c, timer_out);
            end
         end
         if (c == 17) begin
            vectors++;
            if (timer_out !== 4'd3 || tick !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL resume c=%0d: out=%0d tick=%b, want 3 1", c, timer_out, tick);
            end
         end
`endif
      end
   endtask

   task automatic test_zero_load();
      timer_load = 1'b1; timer_init = 4'd0; timer_en = 1'b1;
      @(posedge clk); #1;
      timer_load = 1'b0;
      for (int c = 0; c < 3 * P + 4; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (timer_out !== 4'd0 || done !== 1'b1 || tick !== 1'b0 || expired !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_load c=%0d: out=%0d done=%b tick=%b exp=%b, want 0 1 0 0", c, timer_out, done, tick, expired);
         end
      end
   endtask

   task automatic test_load_at_boundary();
      timer_load = 1'b1; timer_init = 4'd2; timer_en = 1'b1;
      @(posedge clk); #1;
      timer_load = 1'b0;
      repeat (P - 1) @(posedge clk);
      #1;
      timer_load = 1'b1; timer_init = 4'd9;
      @(posedge clk); #1;
      timer_load = 1'b0;
      vectors++;
      if (timer_out !== 4'd9 || tick !== 1'b0 || expired !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL load_wins: out=%0d tick=%b exp=%b, want 9 0 0", timer_out, tick, expired);
      end
      for (int c = 0; c < 9 * P + 3; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (timer_out !== m_out() || tick !== m_tick || expired !== m_expired) begin
            miscompares++;
            $display("[TB] FAIL after_reload c=%0d: out=%0d tick=%b exp=%b, want %0d %b %b", c, timer_out, tick, expired, m_out(), m_tick, m_expired);
         end
      end
   endtask

   task automatic test_reset_mid();
      timer_load = 1'b1; timer_init = 4'd4; timer_en = 1'b1;
      @(posedge clk); #1;
      timer_load = 1'b0;
      repeat (2 * P) @(posedge clk);
      #1;
      vectors++;
      if (timer_out !== 4'd2) begin
         miscompares++;
         $display("[TB] FAIL pre_reset: out=%0d, want 2", timer_out);
      end
      rst = 1'b0; timer_load = 1'b1; timer_init = 4'd6;
      @(posedge clk); #1;
      rst = 1'b1; timer_load = 1'b0;
      vectors++;
      if (timer_out !== 4'd0 || expired !== 1'b0 || tick !== 1'b0 || done !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL mid_reset: out=%0d exp=%b tick=%b done=%b, want 0 0 0 1", timer_out, expired, tick, done);
      end
      for (int c = 0; c < 3 * P + 2; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (timer_out !== 4'd0 || tick !== 1'b0 || expired !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset c=%0d: out=%0d tick=%b exp=%b, want 0 0 0", c, timer_out, tick, expired);
         end
      end
   endtask

`ifndef TRAFFIC_TIMER_PRESCALE_EN
   task automatic test_fast();
      logic [3:0] want [3];
      want[0] = 4'd2; want[1] = 4'd1; want[2] = 4'd0;
      timer_load = 1'b1; timer_init = 4'd3; timer_en = 1'b1;
      @(posedge clk); #1;
      timer_load = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (timer_out !== want[c] || tick !== 1'b1 || expired !== (c == 2)) begin
            miscompares++;
            $display("[TB] FAIL fast c=%0d: out=%0d tick=%b exp=%b, want %0d 1 %b", c, timer_out, tick, expired, want[c], c == 2);
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst        = ($urandom_range(99) != 0);
         timer_load = ($urandom_range(15) == 0);
         timer_en   = ($urandom_range(3) != 0);
         timer_init = 4'($urandom_range(15));
         @(posedge clk); #1;
         vectors++;
         if (timer_out !== m_out() || tick !== m_tick || expired !== m_expired || done !== (m_out() == 4'd0)) begin
            miscompares++;
            $display("[TB] FAIL random c=%0d: out=%0d tick=%b exp=%b done=%b, want %0d %b %b", c, timer_out, tick, expired, done, m_out(), m_tick, m_expired);
         end
      end
      rst = 1'b1; timer_load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_pause();
      test_zero_load();
      test_load_at_boundary();
      test_reset_mid();
`ifndef TRAFFIC_TIMER_PRESCALE_EN
      test_fast();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 Parameter CLKS_PER_TICK, default 50000000, sets clock cycles per timer tick (1 s at 50 MHz); legal range 2..2^26.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 timer_en  input  1  count enable from traffic_light_controller.
REQ-005 timer_load  input  1  load strobe from traffic_light_controller.
REQ-006 timer_init  input  4  value captured on load.
REQ-007 timer_out  output  4  registered remaining tick count; consumed by traffic_light_controller.
REQ-008 done  output  1  combinational, high when timer_out == 0.
REQ-009 expired  output  1  registered one-cycle pulse when a countdown reaches 0.
REQ-010 tick  output  1  registered one-cycle pulse per tick boundary (debug/visibility).

Function
REQ-011 Internal FSM states: IDLE, RUN, DONE.
REQ-012 Prescaler counter width = ceil(log2(CLKS_PER_TICK)) bits, unsigned.
REQ-013 Load has priority: timer_load=1 -> next cycle timer_out=timer_init, prescaler=0, tick=0, expired=0, regardless of timer_en.
REQ-014 After load: state RUN if timer_init != 0, else DONE; load of 0 never produces expired.
REQ-015 timer_en=1, timer_load=0, state RUN: prescaler increments each cycle; at CLKS_PER_TICK-1 it wraps to 0 and tick pulses the following cycle.
REQ-016 On each tick boundary in RUN, timer_out decrements by 1 in the same edge as tick asserts.
REQ-017 Decrement 1 -> 0: expired=1 for exactly that cycle, state -> DONE.
REQ-018 DONE: timer_out held at 0 (saturates, no wrap to 4'hF), prescaler held at 0, no further tick or expired.
REQ-019 timer_en=0 (no load): prescaler and timer_out hold (pause); counting resumes from held prescaler value when re-enabled.
REQ-020 IDLE: entered only by reset; timer_out=0, nothing counts until timer_load=1; timer_en alone does not leave IDLE.
REQ-021 Load in same cycle as a tick boundary: load wins, no decrement, no tick, no expired.
REQ-022 First tick after load with timer_en held high occurs exactly CLKS_PER_TICK cycles after the load edge.

Reset
REQ-023 rst=0 sampled at clk edge: state=IDLE, timer_out=4'h0, prescaler=0, tick=0, expired=0; done=1 consequently.
REQ-024 Reset mid-countdown aborts immediately; no expired pulse generated; reset overrides timer_load.

Configuration
REQ-025 Macro TRAFFIC_TIMER_PRESCALE_EN: defined -> prescaler active per REQ-015; undefined -> prescaler removed, every enabled RUN cycle is a tick boundary (CLKS_PER_TICK ignored), for fast simulation.
REQ-026 All other behaviour, ports and reset values identical in both builds.

Verification (bench uses CLKS_PER_TICK=4, macro defined unless noted)
REQ-027 Reset then load 4'd3, timer_en=1 -> timer_out 3,2,1,0 at 4-cycle spacing; expired high one cycle with the 0; done high thereafter.
REQ-028 Load 4'd5, run 6 cycles, drop timer_en 10 cycles, re-enable -> timer_out holds 4 during pause; next decrement 2 cycles after re-enable.
REQ-029 Load 4'd0 with timer_en=1 -> timer_out=0, done=1, expired never asserts, tick never asserts.
REQ-030 Load 4'd2; assert timer_load with timer_init=4'd9 on the cycle prescaler=3 -> timer_out=9, no decrement, no tick that cycle.
REQ-031 Load 4'd4, rst=0 for one cycle after second tick -> timer_out=0, state IDLE, no expired; timer_en alone keeps timer_out=0.
REQ-032 Macro undefined, load 4'd3, timer_en=1 -> timer_out 2,1,0 on three consecutive cycles; expired on the third.
